// File: rtl/ahb_mailbox_reader.sv
// AHB-Lite master that drains the shared mailbox on interrupt: reads the control
// word, streams payload words on a valid/ready port, then writes the ack word back.
module ahb_mailbox_reader #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] MBOX_BASE  = 32'h0,
  parameter int          MAX_WORDS  = 8192
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  en,
  input  logic                  mailbox_intr,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  input  logic [1:0]            hresp,
  input  logic [DATA_WIDTH-1:0] hrdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [31:0]           m_data,
  output logic [7:0]            m_id,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr,
  output logic [3:0]            dbg_state
);

  // Payload port: a word transfers on any rising edge where m_valid && m_ready;
  // m_data/m_last/m_id stay stable while m_valid is high and m_ready is low.

  typedef enum logic [3:0] {
    S_IDLE, S_CA, S_CD, S_DA, S_DD, S_OUT, S_WA, S_WD
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(MBOX_BASE);
  localparam logic [ADDR_WIDTH-1:0] RAM_ADDR  = ADDR_WIDTH'(MBOX_BASE + 32'h8000);
  localparam logic [14:0]           MAX_N     = 15'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [13:0] idx_q, idx_d;
  logic [14:0] n_q;
  logic [14:0] size_clamp;
  logic        data_phase;
  logic        bus_err;

  assign hsize     = 3'b010;
  assign hburst    = 3'b000;
  assign hprot     = 4'b0011;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  always_comb begin
    size_clamp = (hrdata[22:8] > MAX_N) ? MAX_N : hrdata[22:8];
    data_phase = (state_q == S_CD) || (state_q == S_DD) || (state_q == S_WD);
    // Abort on the first ERROR cycle, without waiting for the second (hready) cycle.
    bus_err    = data_phase && (hresp == 2'b01);
    state_d    = state_q;
    idx_d      = idx_q;
    case (state_q)
      S_IDLE: if (en && mailbox_intr && !err) state_d = S_CA;
      S_CA:   if (hready) state_d = S_CD;
      S_CD: begin
        if (bus_err) state_d = S_IDLE;
        else if (hready) begin
          if (!hrdata[29])           state_d = S_IDLE;
          else if (size_clamp == '0) state_d = S_WA;
          else begin
            state_d = S_DA;
            idx_d   = '0;
          end
        end
      end
      S_DA:   if (hready) state_d = S_DD;
      S_DD: begin
        if (bus_err)     state_d = S_IDLE;
        else if (hready) state_d = S_OUT;
      end
      S_OUT: begin
        if (m_ready) begin
          idx_d   = idx_q + 14'd1;
          state_d = m_last ? S_WA : S_DA;
        end
      end
      S_WA:   if (hready) state_d = S_WD;
      S_WD:   if (bus_err || hready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      haddr   <= '0;
      htrans  <= 2'b00;
      hwrite  <= 1'b0;
      hwdata  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
      m_id    <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // Bus outputs are registered from the next state so each phase lines up with it.
      htrans  <= 2'b00;
      case (state_d)
        S_CA: begin
          htrans <= 2'b10;
          haddr  <= CTRL_ADDR;
          hwrite <= 1'b0;
        end
        S_DA: begin
          htrans <= 2'b10;
          haddr  <= RAM_ADDR + ADDR_WIDTH'({idx_d, 2'b00});
          hwrite <= 1'b0;
        end
        S_WA: begin
          htrans <= 2'b10;
          haddr  <= CTRL_ADDR;
          hwrite <= 1'b1;
        end
        S_WD: hwdata <= DATA_WIDTH'({1'b0, 1'b1, 1'b0, 6'b0, 15'b0, m_id});
        default: ;
      endcase
      if (state_q == S_CD && hready && !bus_err && hrdata[29]) begin
        m_id <= hrdata[7:0];
        n_q  <= size_clamp;
      end
      if (state_q == S_DD && hready && !bus_err) begin
        m_data  <= hrdata[31:0];
        m_valid <= 1'b1;
        m_last  <= ({1'b0, idx_q} == n_q - 15'd1);
      end
      if (state_q == S_OUT && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      if (bus_err)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule
